// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral with a read/write register file exposed as a flat vector.
// Optional macro SPI_ERR_STATUS_EN adds a discarded-frame counter, readable at address NUM_REGS.
module spi_regfile_periph #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         COPI,
    input  logic                         nCS,
    input  logic                         SCLK,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr
);
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    logic [SYNC_STAGES-1:0] copi_sync, ncs_sync, sclk_sync;
    logic                   copi_s, ncs_s, sclk_s, sclk_prev;
    logic                   sclk_rise, sclk_fall;

    // nCS synchroniser resets to the deselected level so nothing looks like a frame start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            sclk_prev <= sclk_s;
        end
    end

    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_LEN-2:0]   shift_sr;
    logic [FRAME_LEN-1:0]   frame_w;
    logic                   shift_en, addr_done, last_bit;
    logic [ADDR_W-1:0]      cmd_addr, f_addr;
    logic                   cmd_rw, f_rw, f_addr_ok;
    logic [DATA_W-1:0]      f_data, rd_val, tx_sr;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic                   is_read, cipo_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ncs_s) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_CMD;
                S_CMD:  if (sclk_rise && bit_cnt == CNT_W'(ADDR_W)) state_nxt = S_DATA;
                S_DATA: if (sclk_rise && bit_cnt == CNT_W'(FRAME_LEN-1)) state_nxt = S_DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // frame_w is the frame as it stands including the bit being sampled this cycle.
    assign shift_en  = sclk_rise && !ncs_s && (state == S_CMD || state == S_DATA);
    assign frame_w   = {shift_sr, copi_s};
    assign addr_done = shift_en && (state == S_CMD)  && (bit_cnt == CNT_W'(ADDR_W));
    assign last_bit  = shift_en && (state == S_DATA) && (bit_cnt == CNT_W'(FRAME_LEN-1));
    assign cmd_addr  = frame_w[ADDR_W-1:0];
    assign cmd_rw    = frame_w[ADDR_W];
    assign f_rw      = frame_w[FRAME_LEN-1];
    assign f_addr    = frame_w[FRAME_LEN-2 -: ADDR_W];
    assign f_data    = frame_w[DATA_W-1:0];
    assign f_addr_ok = {1'b0, f_addr} < NUM_REGS_A;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_sr <= '0;
            bit_cnt  <= '0;
        end else if (ncs_s) begin
            shift_sr <= '0;
            bit_cnt  <= '0;
        end else if (shift_en) begin
            shift_sr <= frame_w[FRAME_LEN-2:0];
            if (bit_cnt != CNT_W'(FRAME_LEN)) bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs      <= '0;
            wr_addr   <= '0;
            wr_strobe <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (last_bit && f_rw && f_addr_ok) begin
                for (int k = 0; k < NUM_REGS; k++)
                    if (f_addr == ADDR_W'(k)) regs[k] <= f_data;
                wr_addr   <= f_addr;
                wr_strobe <= 1'b1;
            end
        end
    end

    assign regs_flat = regs;

`ifdef SPI_ERR_STATUS_EN
    logic [DATA_W-1:0] err_cnt;
    logic              short_frame, bad_wr, clr_wr;

    // A deselect with no bits clocked is treated as line noise, not a short frame.
    assign short_frame = ncs_s && (state == S_CMD || state == S_DATA) && (bit_cnt != '0);
    assign bad_wr      = last_bit && f_rw && ({1'b0, f_addr} > NUM_REGS_A);
    assign clr_wr      = last_bit && f_rw && (f_addr == ADDR_W'(NUM_REGS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_cnt <= '0;
        else if (clr_wr)
            err_cnt <= '0;
        else if ((short_frame || bad_wr) && err_cnt != '1)
            err_cnt <= err_cnt + DATA_W'(1);
    end
`endif

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (cmd_addr == ADDR_W'(k)) rd_val = regs[k];
`ifdef SPI_ERR_STATUS_EN
        if (cmd_addr == ADDR_W'(NUM_REGS)) rd_val = err_cnt;
`endif
    end

    // Read data is snapshotted once the address completes; falling edges in DATA shift it out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_read <= 1'b0;
            tx_sr   <= '0;
            cipo_q  <= 1'b0;
        end else if (ncs_s) begin
            is_read <= 1'b0;
            tx_sr   <= '0;
            cipo_q  <= 1'b0;
        end else if (addr_done) begin
            is_read <= ~cmd_rw;
            tx_sr   <= cmd_rw ? '0 : rd_val;
        end else if (sclk_fall && state == S_DATA && is_read) begin
            cipo_q <= tx_sr[DATA_W-1];
            tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
        end
    end

    assign CIPO    = (state == S_DATA) & cipo_q;
    assign cipo_oe = ~ncs_s;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed bench for spi_regfile_periph: write/read frames, short, unmapped, reset abort, overlong.
module tb_spi_regfile_periph;
    localparam int HP = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        COPI = 1'b0;
    logic        nCS = 1'b1;
    logic        SCLK = 1'b0;
    logic        CIPO, cipo_oe, wr_strobe;
    logic [39:0] regs_flat;
    logic [6:0]  wr_addr;

    int total = 0;
    int bad = 0;
    int stb_hi = 0;
    int stb_pulses = 0;
    logic stb_prev = 1'b0;

    spi_regfile_periph dut (
        .clk(clk), .reset(reset), .COPI(COPI), .nCS(nCS), .SCLK(SCLK),
        .CIPO(CIPO), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) stb_hi++;
        if (wr_strobe && !stb_prev) stb_pulses++;
        stb_prev = wr_strobe;
    end

    task automatic send_bit(input logic b, output logic s);
        COPI = b;
        repeat (HP) @(negedge clk);
        SCLK = 1'b1;
        s = CIPO;
        repeat (HP) @(negedge clk);
        SCLK = 1'b0;
    endtask

    task automatic spi_xfer(input logic [31:0] bits, input int nbits, output logic [7:0] rx);
        logic s;
        rx = '0;
        nCS = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            send_bit(bits[nbits-1-i], s);
            if (i >= 8 && i < 16) rx = {rx[6:0], s};
        end
        repeat (HP) @(negedge clk);
        nCS = 1'b1;
        repeat (HP) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (regs_flat !== 40'h0) begin bad++; $display("FAIL reset_regs got=%h exp=0", regs_flat); end
        total++;
        if ({wr_strobe, CIPO, cipo_oe, wr_addr} !== 10'h0) begin
            bad++; $display("FAIL reset_outs got=%b%b%b %h exp=0", wr_strobe, CIPO, cipo_oe, wr_addr);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] rx;
        int p0, h0;
        p0 = stb_pulses; h0 = stb_hi;
        spi_xfer(32'h80F0, 16, rx);
        total++;
        if (regs_flat !== 40'h00_00_00_00_F0) begin bad++; $display("FAIL write0_regs got=%h exp=00000000f0", regs_flat); end
        total++;
        if (stb_pulses - p0 != 1 || stb_hi - h0 != 1) begin
            bad++; $display("FAIL write0_strobe pulses=%0d cycles=%0d exp=1/1", stb_pulses - p0, stb_hi - h0);
        end
        total++;
        if (wr_addr !== 7'd0) begin bad++; $display("FAIL write0_addr got=%0d exp=0", wr_addr); end
    endtask

    task automatic test_read();
        logic [7:0] rx;
        spi_xfer(32'h8480, 16, rx);
        total++;
        if (regs_flat[39:32] !== 8'h80 || wr_addr !== 7'd4) begin
            bad++; $display("FAIL write4 got=%h addr=%0d exp=80 addr=4", regs_flat[39:32], wr_addr);
        end
        spi_xfer(32'h0400, 16, rx);
        total++;
        if (rx !== 8'h80) begin bad++; $display("FAIL read4 got=%h exp=80", rx); end
        spi_xfer(32'h0000, 16, rx);
        total++;
        if (rx !== 8'hF0) begin bad++; $display("FAIL read0 got=%h exp=f0", rx); end
        total++;
        if (cipo_oe !== 1'b0 || CIPO !== 1'b0) begin bad++; $display("FAIL idle_pins oe=%b cipo=%b exp=0/0", cipo_oe, CIPO); end
    endtask

    task automatic test_short();
        logic [7:0] rx;
        int p0;
        p0 = stb_pulses;
        spi_xfer(32'h81A5 >> 4, 12, rx);
        total++;
        if (regs_flat !== 40'h80_00_00_00_F0 || stb_pulses != p0) begin
            bad++; $display("FAIL short_frame regs=%h pulses=%0d exp=80000000f0/0", regs_flat, stb_pulses - p0);
        end
`ifdef SPI_ERR_STATUS_EN
        spi_xfer(32'h0500, 16, rx);
        total++;
        if (rx !== 8'h01) begin bad++; $display("FAIL status_short got=%h exp=01", rx); end
`endif
    endtask

    task automatic test_unmapped();
        logic [7:0] rx;
        int p0;
        p0 = stb_pulses;
        spi_xfer(32'hFF55, 16, rx);
        total++;
        if (regs_flat !== 40'h80_00_00_00_F0 || stb_pulses != p0) begin
            bad++; $display("FAIL unmapped_write regs=%h pulses=%0d exp=80000000f0/0", regs_flat, stb_pulses - p0);
        end
        spi_xfer(32'h7F00, 16, rx);
        total++;
        if (rx !== 8'h00) begin bad++; $display("FAIL unmapped_read got=%h exp=00", rx); end
`ifdef SPI_ERR_STATUS_EN
        spi_xfer(32'h0500, 16, rx);
        total++;
        if (rx !== 8'h02) begin bad++; $display("FAIL status_unmapped got=%h exp=02", rx); end
        spi_xfer(32'h8500, 16, rx);
        spi_xfer(32'h0500, 16, rx);
        total++;
        if (rx !== 8'h00 || stb_pulses != p0) begin
            bad++; $display("FAIL status_clear got=%h pulses=%0d exp=00/0", rx, stb_pulses - p0);
        end
`endif
    endtask

    task automatic test_reset_abort();
        logic [15:0] fr;
        logic [7:0]  rx;
        logic s;
        fr = 16'h83C3;
        nCS = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < 10; i++) send_bit(fr[15-i], s);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({regs_flat, wr_addr, wr_strobe, CIPO, cipo_oe} !== 50'h0) begin
            bad++; $display("FAIL abort_outs regs=%h addr=%0d stb=%b cipo=%b oe=%b exp=0",
                            regs_flat, wr_addr, wr_strobe, CIPO, cipo_oe);
        end
        nCS = 1'b1;
        COPI = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        spi_xfer(32'h83C3, 16, rx);
        total++;
        if (regs_flat !== 40'h00_C3_00_00_00 || wr_addr !== 7'd3) begin
            bad++; $display("FAIL after_abort regs=%h addr=%0d exp=00c3000000 addr=3", regs_flat, wr_addr);
        end
    endtask

    task automatic test_overlong();
        logic [7:0] rx;
        int p0;
        p0 = stb_pulses;
        spi_xfer({12'h0, 16'h8211, 4'hF}, 20, rx);
        total++;
        if (regs_flat !== 40'h00_C3_11_00_00 || wr_addr !== 7'd2) begin
            bad++; $display("FAIL overlong_regs regs=%h addr=%0d exp=00c3110000 addr=2", regs_flat, wr_addr);
        end
        total++;
        if (stb_pulses - p0 != 1) begin bad++; $display("FAIL overlong_strobe got=%0d exp=1", stb_pulses - p0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rx;
        spi_xfer(32'h8277, 16, rx);
        spi_xfer(32'h0200, 16, rx);
        total++;
        if (rx !== 8'h77) begin bad++; $display("FAIL wr_then_rd got=%h exp=77", rx); end
        spi_xfer(32'h0300, 16, rx);
        total++;
        if (rx !== 8'hC3) begin bad++; $display("FAIL read3 got=%h exp=c3", rx); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_short();
        test_unmapped();
        test_reset_abort();
        test_overlong();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_regfile_periph.md
Name: spi_regfile_periph

Overview:
Parametrised SPI mode-0 peripheral with a generic register file. It supports writes and reads, with configurable address width, data width and register count. It sits between the chip's SPI pins and the control logic (output enables, PWM), exposing all registers as one flat vector. It supersedes the fixed 5x8-bit write-only register peripheral.

Parameters:
ADDR_W, 7, address field width in bits.
DATA_W, 8, data field and register width in bits.
NUM_REGS, 5, number of implemented registers (addresses 0..NUM_REGS-1); must be <= 2**ADDR_W.
SYNC_STAGES, 2, flip-flop stages on COPI/nCS/SCLK synchronisers; minimum 2.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous active-low reset.
COPI  input  1  SPI data from controller.
nCS  input  1  SPI chip select, active low.
SCLK  input  1  SPI clock, idle low.
CIPO  output  1  SPI data to controller.
cipo_oe  output  1  CIPO output enable, high while the chip is selected.
regs_flat  output  NUM_REGS*DATA_W  register contents; reg k at [k*DATA_W +: DATA_W].
wr_strobe  output  1  one-clk pulse on each committed write.
wr_addr  output  ADDR_W  address of the last committed write.

Behaviour:
- Frame format, MSB first, FRAME_LEN = 1+ADDR_W+DATA_W bits (default 16):
  - bit 0: R/W, 1 = write, 0 = read.
  - next ADDR_W bits: address.
  - next DATA_W bits: data.
- Synchronisers:
  - COPI, nCS and SCLK each pass through SYNC_STAGES flops.
  - SCLK edges are detected by comparing against a previous-value flop.
  - Pin-to-detected-edge latency is SYNC_STAGES+1 clk cycles.
  - Required operating ratio: clk >= 8x SCLK.
- Reset (async, reset low):
  - All registers, regs_flat, wr_addr, shift register and bit counter clear to 0.
  - wr_strobe = 0, CIPO = 0.
  - Reset asserted mid-frame aborts the frame with no write.
- States: IDLE (nCS_sync high), then CMD (receiving R/W and address), then DATA (FRAME_LEN-1-ADDR_W bits remaining), then DONE.
  - Any state returns to IDLE when nCS_sync goes high.
  - nCS_sync high clears the bit counter and shift register.
- Write path:
  - On each detected SCLK rising edge in CMD or DATA, shift in COPI and increment the bit counter.
  - The counter is $clog2(FRAME_LEN+1) bits wide and saturates at FRAME_LEN.
  - On the clk edge that samples bit FRAME_LEN-1, with R/W = 1 and address < NUM_REGS:
    - update the register;
    - set wr_addr to the address;
    - assert wr_strobe for exactly one cycle.
  - Address >= NUM_REGS: no update, no strobe.
- Read path:
  - When the bit that completes the address is sampled with R/W = 0, latch the addressed register into an output shift register.
  - An unmapped address latches 0.
  - The latched value is a snapshot; later register changes do not affect it.
  - On each detected SCLK falling edge in DATA, drive the next bit MSB first.
  - The first falling edge after the address phase presents the data MSB.
  - CIPO = 0 outside the data phase of a read.
  - cipo_oe = ~nCS_sync.
- DONE: SCLK edges beyond FRAME_LEN are ignored, giving no second commit and CIPO = 0. Leaving DONE requires nCS_sync high.
- Short frame (nCS_sync rises before FRAME_LEN bits): discarded, no register change.
- Simultaneous nCS_sync rise and final SCLK rising edge in the same clk: nCS wins and the frame is discarded.
- A write and a read in consecutive frames to the same address: the read returns the new value.

Optional Feature:
SPI_ERR_STATUS_EN:
- Defined:
  - Adds a read-only status register at address NUM_REGS (requires NUM_REGS < 2**ADDR_W).
  - It is a DATA_W-bit saturating count of discarded frames: short frames, and writes to unmapped or read-only addresses.
  - Writing address NUM_REGS, with any data, clears it to 0; that write is not counted as an error.
  - Reset value 0.
  - Not part of regs_flat.
- Undefined: the status register and counter are absent, and address NUM_REGS behaves as unmapped.

Test Plan:
1. Reset, then write frame 0x80F0 (addr 0, data 0xF0) -> regs_flat[7:0] = 0xF0; wr_strobe high one cycle; wr_addr = 0; other registers 0.
2. Write 0x8480, then read frame 0x04xx -> regs_flat[39:32] = 0x80; CIPO bits on the read data phase = 1,0,0,0,0,0,0,0 (0x80), sampled on SCLK rising edges.
3. Send 12 SCLK edges of 0x81A5, then raise nCS -> no register change, no strobe; with SPI_ERR_STATUS_EN, status read = 0x01.
4. Write 0xFF55 (addr 0x7F, unmapped) -> no change, no strobe. Read 0x7Fxx -> CIPO all 0. With the macro, status increments; writing 0x8500 then clears it.
5. Assert reset after bit 10 of 0x83C3 -> all outputs 0. A full frame after reset release writes 0xC3 to reg 3.
6. Send 20 SCLK edges in one frame 0x8211 + 0xF -> reg 2 = 0x11 and exactly one wr_strobe pulse.
